// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3 codes,
// FSM states and the store byte-enable decode.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    // Little-endian lane mask for a store; unsupported widths select no lanes.
    function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_B:    byte_enables = 4'b0001 << addr;
            F3_H:    byte_enables = addr[1] ? 4'b1100 : 4'b0011;
            F3_W:    byte_enables = 4'b1111;
            default: byte_enables = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte write enables and a registered read port.
// A same-edge write to the word being read is forwarded so the read sees new data.
module dmem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [LANES-1:0][7:0] mem [DEPTH];
    logic [DATA_W-1:0]     rdata_reg;

    always_ff @(posedge clk) begin
        for (int b = 0; b < LANES; b++) begin
            if (we && be[b]) begin
                mem[waddr][b] <= wdata[8*b +: 8];
            end
            if (we && be[b] && (waddr == raddr)) begin
                rdata_reg[8*b +: 8] <= wdata[8*b +: 8];
            end else begin
                rdata_reg[8*b +: 8] <= mem[raddr][b];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency request/response data memory for the MEM stage: RV32I byte/half/word
// access with alignment checks and sign/zero extension, one response pulse per request.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int WORD_W = DM_ADDRESS - 2;

    dmem_state_t           state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  we_reg;
    logic [DM_ADDRESS-1:0] addr_reg;
    logic [2:0]            f3_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic                  rsp_valid_reg;
    logic [DATA_W-1:0]     rsp_rdata_reg;
    logic                  rsp_err_reg;

    logic                  accept;
    logic                  commit;
    logic                  err;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     rd_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_W-1:0]     ld_data;

    assign req_ready = (state_reg == IDLE) || (state_reg == RESP);
    assign accept    = req_valid && req_ready;
    // The edge taken while in RESP is the response edge of the pending request.
    assign commit    = (state_reg == RESP);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (accept) begin
                    state_next = (LATENCY > 1) ? BUSY : RESP;
                    cnt_next   = 4'(LATENCY - 1);
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            f3_reg    <= 3'b000;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr;
                f3_reg    <= req_funct3;
                wdata_reg <= req_wdata;
            end
        end
    end

    always_comb begin
        err = 1'b0;
        case (f3_reg)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_reg[0];
            F3_W:    err = |addr_reg[1:0];
            F3_BU:   err = we_reg;
            F3_HU:   err = we_reg | addr_reg[0];
            default: err = 1'b1;
        endcase
    end

    // Replicate narrow store data across the word; byte enables pick the live lanes.
    always_comb begin
        mem_wdata = wdata_reg;
        case (f3_reg)
            F3_B:    mem_wdata = {(DATA_W/8){wdata_reg[7:0]}};
            F3_H:    mem_wdata = {(DATA_W/16){wdata_reg[15:0]}};
            default: mem_wdata = wdata_reg;
        endcase
    end

    assign mem_we = commit && we_reg && !err;

    // Reading at the accept address keeps LATENCY=1 correct; longer latencies re-read later.
    dmem_array #(
        .ADDR_W (WORD_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (byte_enables(f3_reg, addr_reg[1:0])),
        .waddr (addr_reg[DM_ADDRESS-1:2]),
        .wdata (mem_wdata),
        .raddr (accept ? req_addr[DM_ADDRESS-1:2] : addr_reg[DM_ADDRESS-1:2]),
        .rdata (rd_word)
    );

    assign ld_byte = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    assign ld_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = '0;
        case (f3_reg)
            F3_B:    ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            F3_H:    ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            F3_W:    ld_data = rd_word;
            default: ld_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= commit;
            if (commit) begin
                rsp_rdata_reg <= (err || we_reg) ? '0 : ld_data;
                rsp_err_reg   <= err;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at acceptance
// and matched in order against captured rsp_valid pulses, including their timing.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          edge_no;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t act_q[$];
    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Capture every response pulse with the index of the edge it follows.
    always @(negedge clk) begin : monitor
        rsp_t r;
        if (rsp_valid === 1'b1) begin
            r.d = rsp_rdata;
            r.e = rsp_err;
            r.edge_no = edge_n;
            act_q.push_back(r);
            $display("rsp  edge=%0d data=%h err=%0b", edge_n, rsp_rdata, rsp_err);
        end
    end

    task automatic send(input logic we, input logic [8:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input bit track, output int acc);
        int   waited;
        rsp_t r;
        waited = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b required=1", req_ready);
            acc = -1;
            return;
        end
        acc = edge_n + 1;
        if (track) begin
            r.d = ed;
            r.e = ee;
            r.edge_no = acc + LAT;
            exp_q.push_back(r);
        end
        $display("req  edge=%0d we=%0b addr=%h f3=%b wdata=%h", acc, we, a, f3, wd);
        @(posedge clk);
    endtask

    task automatic drain();
        int w;
        w = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (act_q.size() < exp_q.size() && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", rsp_err); end
        reset = 1'b1;
    endtask

    task automatic test_word();
        int   acc;
        rsp_t e, a;
        send(1, 9'h010, 3'b010, 32'hDEADBEEF, 32'h0, 0, 1, acc);
        send(0, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0, 1, acc);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (act_q.size() == 0) begin n_fail++; $display("FAIL word_missing: got none required data=%h err=%0b", e.d, e.e); end
            else begin
                a = act_q.pop_front();
                if (a.d !== e.d || a.e !== e.e || a.edge_no !== e.edge_no) begin n_fail++;
                    $display("FAIL word_rsp: got %h/%0b@%0d required %h/%0b@%0d", a.d, a.e, a.edge_no, e.d, e.e, e.edge_no); end
            end
        end
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("FAIL word_extra: got %0d extra required 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_byte();
        int   acc;
        rsp_t e, a;
        send(1, 9'h013, 3'b000, 32'h00000080, 32'h0, 0, 1, acc);
        send(0, 9'h013, 3'b000, 32'h0, 32'hFFFFFF80, 0, 1, acc);
        send(0, 9'h013, 3'b100, 32'h0, 32'h00000080, 0, 1, acc);
        send(0, 9'h010, 3'b010, 32'h0, 32'h80ADBEEF, 0, 1, acc);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (act_q.size() == 0) begin n_fail++; $display("FAIL byte_missing: got none required data=%h err=%0b", e.d, e.e); end
            else begin
                a = act_q.pop_front();
                if (a.d !== e.d || a.e !== e.e || a.edge_no !== e.edge_no) begin n_fail++;
                    $display("FAIL byte_rsp: got %h/%0b@%0d required %h/%0b@%0d", a.d, a.e, a.edge_no, e.d, e.e, e.edge_no); end
            end
        end
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("FAIL byte_extra: got %0d extra required 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_half();
        int   acc;
        rsp_t e, a;
        send(1, 9'h01C, 3'b010, 32'h55667788, 32'h0, 0, 1, acc);
        send(1, 9'h01E, 3'b001, 32'h1234ABCD, 32'h0, 0, 1, acc);
        send(0, 9'h01E, 3'b001, 32'h0, 32'hFFFFABCD, 0, 1, acc);
        send(0, 9'h01E, 3'b101, 32'h0, 32'h0000ABCD, 0, 1, acc);
        send(0, 9'h01C, 3'b010, 32'h0, 32'hABCD7788, 0, 1, acc);
        send(1, 9'h1FC, 3'b010, 32'h0BADCAFE, 32'h0, 0, 1, acc);
        send(0, 9'h1FF, 3'b000, 32'h0, 32'h0000000B, 0, 1, acc);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (act_q.size() == 0) begin n_fail++; $display("FAIL half_missing: got none required data=%h err=%0b", e.d, e.e); end
            else begin
                a = act_q.pop_front();
                if (a.d !== e.d || a.e !== e.e || a.edge_no !== e.edge_no) begin n_fail++;
                    $display("FAIL half_rsp: got %h/%0b@%0d required %h/%0b@%0d", a.d, a.e, a.edge_no, e.d, e.e, e.edge_no); end
            end
        end
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("FAIL half_extra: got %0d extra required 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_errors();
        int   acc;
        rsp_t e, a;
        send(0, 9'h011, 3'b001, 32'h0, 32'h0, 1, 1, acc);
        send(1, 9'h012, 3'b010, 32'hFFFFFFFF, 32'h0, 1, 1, acc);
        send(1, 9'h011, 3'b001, 32'hFFFFFFFF, 32'h0, 1, 1, acc);
        send(1, 9'h010, 3'b100, 32'hFFFFFFFF, 32'h0, 1, 1, acc);
        send(0, 9'h010, 3'b010, 32'h0, 32'h80ADBEEF, 0, 1, acc);
        send(0, 9'h010, 3'b011, 32'h0, 32'h0, 1, 1, acc);
        send(0, 9'h010, 3'b110, 32'h0, 32'h0, 1, 1, acc);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (act_q.size() == 0) begin n_fail++; $display("FAIL err_missing: got none required data=%h err=%0b", e.d, e.e); end
            else begin
                a = act_q.pop_front();
                if (a.d !== e.d || a.e !== e.e || a.edge_no !== e.edge_no) begin n_fail++;
                    $display("FAIL err_rsp: got %h/%0b@%0d required %h/%0b@%0d", a.d, a.e, a.edge_no, e.d, e.e, e.edge_no); end
            end
        end
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("FAIL err_extra: got %0d extra required 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_back_to_back();
        int   acc0, acc1, acc2;
        rsp_t e, a;
        send(0, 9'h010, 3'b010, 32'h0, 32'h80ADBEEF, 0, 1, acc0);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy0: req_ready=%b required 0", req_ready); end
        send(0, 9'h01C, 3'b010, 32'h0, 32'hABCD7788, 0, 1, acc1);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy1: req_ready=%b required 0", req_ready); end
        send(0, 9'h1FC, 3'b010, 32'h0, 32'h0BADCAFE, 0, 1, acc2);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy2: req_ready=%b required 0", req_ready); end
        n_cmp++; if (acc1 - acc0 != 2 || acc2 - acc1 != 2) begin n_fail++;
            $display("FAIL b2b_spacing: accept gaps %0d,%0d required 2,2", acc1 - acc0, acc2 - acc1); end
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (act_q.size() == 0) begin n_fail++; $display("FAIL b2b_missing: got none required data=%h err=%0b", e.d, e.e); end
            else begin
                a = act_q.pop_front();
                if (a.d !== e.d || a.e !== e.e || a.edge_no !== e.edge_no) begin n_fail++;
                    $display("FAIL b2b_rsp: got %h/%0b@%0d required %h/%0b@%0d", a.d, a.e, a.edge_no, e.d, e.e, e.edge_no); end
            end
        end
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra required 0", act_q.size()); act_q.delete(); end
    endtask

    task automatic test_reset_midop();
        int   acc;
        rsp_t e, a;
        send(1, 9'h020, 3'b010, 32'hCAFEF00D, 32'h0, 0, 1, acc);
        drain();
        exp_q.delete();
        act_q.delete();
        send(1, 9'h020, 3'b010, 32'h11111111, 32'h0, 0, 0, acc);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b required 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b required 0", rsp_valid); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("FAIL midreset_pulse: got %0d pulses required 0", act_q.size()); act_q.delete(); end
        send(0, 9'h020, 3'b010, 32'h0, 32'hCAFEF00D, 0, 1, acc);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (act_q.size() == 0) begin n_fail++; $display("FAIL midreset_missing: got none required data=%h err=%0b", e.d, e.e); end
            else begin
                a = act_q.pop_front();
                if (a.d !== e.d || a.e !== e.e || a.edge_no !== e.edge_no) begin n_fail++;
                    $display("FAIL midreset_rsp: got %h/%0b@%0d required %h/%0b@%0d", a.d, a.e, a.edge_no, e.d, e.e, e.edge_no); end
            end
        end
        n_cmp++; if (act_q.size() != 0) begin n_fail++; $display("FAIL midreset_extra: got %0d extra required 0", act_q.size()); act_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
